// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers one result per functional unit and broadcasts one per cycle on the CDB, round robin
module cdb_arbiter #(
   parameter int N_UNITS = 4,
   parameter int TAG_W = 8,
   parameter int WORD_W = 32,
   parameter logic [TAG_W-1:0] IDLE_TAG = 8'b01111111
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic [N_UNITS-1:0]        req_valid,
   input  logic [N_UNITS*TAG_W-1:0]  req_tag,
   input  logic [N_UNITS*WORD_W-1:0] req_value,
   output logic [N_UNITS-1:0]        req_ready,
   output logic                      cdb_valid,
   output logic [TAG_W-1:0]          cdb_tag,
   output logic [WORD_W-1:0]         cdb_value,
   output logic                      drop_err
);
   localparam int PW = N_UNITS > 1 ? $clog2(N_UNITS) : 1;

   logic [N_UNITS-1:0] slot_full_q, slot_full_d, grant;
   logic [TAG_W-1:0]   slot_tag_q [N_UNITS];
   logic [TAG_W-1:0]   slot_tag_d [N_UNITS];
   logic [WORD_W-1:0]  slot_value_q [N_UNITS];
   logic [WORD_W-1:0]  slot_value_d [N_UNITS];
   logic [PW-1:0]      rr_q, rr_d, gidx;
   logic               found;
   logic               cdb_valid_q, cdb_valid_d, drop_q, drop_d;
   logic [TAG_W-1:0]   cdb_tag_q, cdb_tag_d;
   logic [WORD_W-1:0]  cdb_value_q, cdb_value_d;
   int                 j;

   // round-robin grant search from rr_q, then broadcast / accept / flush next-state
   always_comb begin
      grant = '0;
      gidx = '0;
      found = 1'b0;
      j = 0;
      for (int k = 0; k < N_UNITS; k++) begin
         j = int'(rr_q) + k;
         if (j >= N_UNITS) j = j - N_UNITS;
         if (!found && slot_full_q[j]) begin
            found = 1'b1;
            grant[j] = 1'b1;
            gidx = PW'(j);
         end
      end
      req_ready = ~slot_full_q | grant;
      slot_full_d = slot_full_q & ~grant;
      slot_tag_d = slot_tag_q;
      slot_value_d = slot_value_q;
      rr_d = found ? ((int'(gidx) == N_UNITS - 1) ? '0 : gidx + 1'b1) : rr_q;
      cdb_valid_d = found;
      cdb_tag_d = found ? slot_tag_q[gidx] : IDLE_TAG;
      cdb_value_d = found ? slot_value_q[gidx] : '0;
      drop_d = 1'b0;
      for (int i = 0; i < N_UNITS; i++) begin
         if (req_valid[i] && req_ready[i]) begin
            if (req_tag[i*TAG_W +: TAG_W] == IDLE_TAG) begin
               drop_d = 1'b1;
            end else begin
               slot_full_d[i] = 1'b1;
               slot_tag_d[i] = req_tag[i*TAG_W +: TAG_W];
               slot_value_d[i] = req_value[i*WORD_W +: WORD_W];
            end
         end
      end
      if (flush) begin
         slot_full_d = '0;
         rr_d = rr_q;
         cdb_valid_d = 1'b0;
         cdb_tag_d = IDLE_TAG;
         cdb_value_d = '0;
         drop_d = 1'b0;
      end
   end

   // state registers; slot payloads are only meaningful while slot_full is set
   always_ff @(posedge clk) begin
      slot_tag_q <= slot_tag_d;
      slot_value_q <= slot_value_d;
      if (rst) begin
         slot_full_q <= '0;
         rr_q <= '0;
         cdb_valid_q <= 1'b0;
         cdb_tag_q <= IDLE_TAG;
         cdb_value_q <= '0;
         drop_q <= 1'b0;
      end else begin
         slot_full_q <= slot_full_d;
         rr_q <= rr_d;
         cdb_valid_q <= cdb_valid_d;
         cdb_tag_q <= cdb_tag_d;
         cdb_value_q <= cdb_value_d;
         drop_q <= drop_d;
      end
   end

   assign cdb_valid = cdb_valid_q;
   assign cdb_tag = cdb_tag_q;
   assign cdb_value = cdb_value_q;
   assign drop_err = drop_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed and random stimulus checked against a slot-level reference model
module tb_cdb_arbiter;
   localparam int N = 4;
   localparam int TW = 8;
   localparam int WW = 32;
   localparam logic [TW-1:0] IDLE = 8'h7F;

   logic clk = 1'b0;
   logic rst, flush;
   logic [N-1:0] req_valid, req_ready;
   logic [N*TW-1:0] req_tag;
   logic [N*WW-1:0] req_value;
   logic cdb_valid, drop_err;
   logic [TW-1:0] cdb_tag;
   logic [WW-1:0] cdb_value;

   always #5 clk = ~clk;

   cdb_arbiter dut (
      .clk(clk), .rst(rst), .flush(flush),
      .req_valid(req_valid), .req_tag(req_tag), .req_value(req_value), .req_ready(req_ready),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .drop_err(drop_err)
   );

   int checks = 0;
   int errors = 0;
   bit mknown = 1'b0;
   bit mfull [N];
   logic [TW-1:0] mtag [N];
   logic [WW-1:0] mval [N];
   int mrr = 0;
   logic ev, ed;
   logic [TW-1:0] et;
   logic [WW-1:0] evl;
   logic [N-1:0] last_ready;

   task automatic chk(input string what, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", what, obs, exp);
      end
   endtask

   // one clock: drive, check ready before the edge, advance model, check registered outputs after it
   task automatic step(input logic r, input logic f, input logic [N-1:0] v,
                       input logic [N*TW-1:0] t, input logic [N*WW-1:0] d);
      int g;
      bit rdy [N];
      rst = r; flush = f; req_valid = v; req_tag = t; req_value = d;
      #1;
      g = -1;
      for (int k = 0; k < N; k++) if (g < 0 && mfull[(mrr + k) % N]) g = (mrr + k) % N;
      for (int i = 0; i < N; i++) rdy[i] = !mfull[i] || i == g;
      last_ready = req_ready;
      if (mknown) for (int i = 0; i < N; i++) chk("req_ready", 64'(req_ready[i]), 64'(rdy[i]));
      if (r || f) begin
         for (int i = 0; i < N; i++) mfull[i] = 1'b0;
         ev = 1'b0; et = IDLE; evl = '0; ed = 1'b0;
         if (r) begin mrr = 0; mknown = 1'b1; end
      end else begin
         ev = g >= 0;
         et = (g >= 0) ? mtag[g] : IDLE;
         evl = (g >= 0) ? mval[g] : '0;
         ed = 1'b0;
         if (g >= 0) begin mfull[g] = 1'b0; mrr = (g + 1) % N; end
         for (int i = 0; i < N; i++)
            if (v[i] && rdy[i]) begin
               if (t[i*TW +: TW] == IDLE) ed = 1'b1;
               else begin mfull[i] = 1'b1; mtag[i] = t[i*TW +: TW]; mval[i] = d[i*WW +: WW]; end
            end
      end
      @(posedge clk);
      @(negedge clk);
      chk("cdb_valid", 64'(cdb_valid), 64'(ev));
      chk("cdb_tag", 64'(cdb_tag), 64'(et));
      chk("cdb_value", 64'(cdb_value), 64'(evl));
      chk("drop_err", 64'(drop_err), 64'(ed));
   endtask

   initial begin
      logic [N*TW-1:0] rt;
      logic [N*WW-1:0] rv;
      bit seen;
      int n0;
      rst = 1'b1; flush = 1'b0; req_valid = '0; req_tag = '0; req_value = '0;
      @(negedge clk);
      // reset with all units requesting: nothing may be stored
      step(1, 0, 4'hF, 32'h13121110, {4{32'h1}});
      step(1, 0, 4'hF, 32'h13121110, {4{32'h1}});
      chk("reset_tag", 64'(cdb_tag), 64'h7F);
      step(0, 0, 4'h0, '0, '0);
      chk("reset_no_slot", 64'(cdb_valid), 64'h0);
      // single result from unit 2
      step(0, 0, 4'b0100, 32'h00120000, {32'h0, 32'hFFFFFFFB, 64'h0});
      chk("single_ready", 64'(last_ready[2]), 64'h1);
      step(0, 0, 4'h0, '0, '0);
      chk("single_valid", 64'(cdb_valid), 64'h1);
      chk("single_tag", 64'(cdb_tag), 64'h12);
      chk("single_value", 64'(cdb_value), 64'hFFFFFFFB);
      step(0, 0, 4'h0, '0, '0);
      chk("single_once", 64'(cdb_valid), 64'h0);
      // round robin from rr_ptr 0
      step(1, 0, 4'h0, '0, '0);
      step(0, 0, 4'hF, 32'h13121110, {32'd3, 32'd2, 32'd1, 32'd0});
      for (int k = 0; k < N; k++) begin
         step(0, 0, 4'h0, '0, '0);
         chk("rr_order", 64'(cdb_tag), 64'(8'h10 + k));
      end
      // unit 0 streams continuously, unit 3 sends once and must get through within 4 broadcasts
      seen = 1'b0;
      n0 = 0;
      step(0, 0, 4'b1001, {8'h33, 16'h0, 8'h20}, {32'd33, 64'h0, 32'd20});
      for (int k = 0; k < 6; k++) begin
         step(0, 0, 4'b0001, 32'(8'h21 + n0), 128'(32'd21 + n0));
         if (last_ready[0]) n0++;
         if (k < 4 && cdb_valid && cdb_tag == 8'h33) seen = 1'b1;
      end
      chk("fair_unit3", 64'(seen), 64'h1);
      // blocked slot: fill unit 1, keep rr elsewhere, unit 1 holds until accepted
      step(1, 0, 4'h0, '0, '0);
      step(0, 0, 4'b0011, 32'h00005150, {64'h0, 32'd51, 32'd50});
      for (int k = 0; k < 4; k++) step(0, 0, 4'b0010, 32'(16'h5200), 128'(64'd52 << 32));
      // flush with three slots full: none of them may appear
      step(1, 0, 4'h0, '0, '0);
      step(0, 0, 4'b0111, 32'h00424140, {32'h0, 32'd42, 32'd41, 32'd40});
      step(0, 1, 4'h0, '0, '0);
      chk("flush_idle", 64'(cdb_valid), 64'h0);
      seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step(0, 0, 4'h0, '0, '0);
         if (cdb_valid) seen = 1'b1;
      end
      chk("flush_discard", 64'(seen), 64'h0);
      // IDLE_TAG request is accepted and dropped
      step(0, 0, 4'b0001, 32'h0000007F, 128'd9);
      chk("idle_ready", 64'(last_ready[0]), 64'h1);
      chk("idle_drop", 64'(drop_err), 64'h1);
      step(0, 0, 4'h0, '0, '0);
      chk("idle_drop_once", 64'(drop_err), 64'h0);
      chk("idle_no_bcast", 64'(cdb_valid), 64'h0);
      // random traffic
      for (int k = 0; k < 500; k++) begin
         rt = {$urandom, $urandom} >> 32;
         rt = N*TW'($urandom);
         for (int i = 0; i < N; i++) if ($urandom_range(0, 7) == 0) rt[i*TW +: TW] = IDLE;
         rv = {$urandom, $urandom, $urandom, $urandom};
         step($urandom_range(0, 79) == 0, $urandom_range(0, 29) == 0, N'($urandom_range(0, 15)), rt, rv);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
